mem_request_issuer: RTL and testbench
=====================================

MEM_REQUEST_ISSUER -- requirements
Module: mem_request_issuer

Interface
REQ-001 The block SHALL have no parameters: address and data widths are fixed at 32 bits and the latency field at 4 bits.
REQ-002 The block SHALL have one clock, clk; reset is rst, asynchronous and active-high.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst  input  1  async active-high reset.
REQ-005 Port req_valid  input  1  requester presents an access.
REQ-006 Port req_ready  output  1  block can accept an access this cycle.
REQ-007 Port req_we  input  1  1 = write, 0 = read.
REQ-008 Port req_addr  input  32  access address.
REQ-009 Port req_wdata  input  32  write data.
REQ-010 Port latency  input  4  extra wait cycles the memory needs, sampled at accept.
REQ-011 Port mem_en  output  1  memory access strobe, held for the whole access.
REQ-012 Port mem_we  output  1  memory write enable.
REQ-013 Port mem_addr  output  32  memory address.
REQ-014 Port mem_wdata  output  32  memory write data.
REQ-015 Port mem_rdata  input  32  memory read data, valid in the final access cycle.
REQ-016 Port rsp_valid  output  1  one-cycle completion pulse.
REQ-017 Port rsp_rdata  output  32  last completed read data.
REQ-018 Port busy  output  1  high whenever the block is not in IDLE.

Function
REQ-019 The state machine SHALL have three states: IDLE, ACCESS and RESPOND.
REQ-020 In IDLE, req_ready SHALL be 1; in ACCESS and RESPOND, req_ready SHALL be 0.
REQ-021 In IDLE with req_valid=1, the block SHALL capture req_we, req_addr, req_wdata and latency on that edge and enter ACCESS.
REQ-022 req_valid while req_ready=0 SHALL be ignored; no queueing, no capture.
REQ-023 In ACCESS, mem_en SHALL be 1, and mem_we, mem_addr and mem_wdata SHALL drive the captured values, stable for the whole ACCESS.
REQ-024 The 4-bit wait counter SHALL load the captured latency on entry to ACCESS and decrement by 1 per ACCESS cycle while nonzero.
REQ-025 The ACCESS cycle in which the counter is 0 SHALL be the final access cycle; ACCESS therefore lasts exactly latency+1 cycles (latency=0 -> 1 cycle; latency=15 -> 16 cycles).
REQ-026 The counter SHALL never wrap below 0.
REQ-027 On the final access cycle of a read, rsp_rdata SHALL be loaded from mem_rdata.
REQ-028 On the final access cycle of a write, rsp_rdata SHALL keep its previous value.
REQ-029 After the final access cycle the block SHALL enter RESPOND.
REQ-030 In RESPOND, rsp_valid SHALL be 1 for exactly one cycle and the block SHALL then return to IDLE.
REQ-031 Outside ACCESS, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold the last captured values.
REQ-032 Changes on latency, req_addr, req_wdata and req_we after accept SHALL have no effect on the access in progress.
REQ-033 Minimum accept-to-accept spacing SHALL be latency+3 cycles: 1 accept cycle, then latency+1 ACCESS cycles, then 1 RESPOND cycle.
REQ-034 busy SHALL equal (state != IDLE).
REQ-035 rsp_rdata SHALL remain stable between completions.

Reset
REQ-036 While rst=1, the block SHALL be in IDLE, with the counter and all capture registers at 0.
REQ-037 While rst=1, the outputs SHALL be: req_ready=1, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, busy=0.
REQ-038 Assertion of rst mid-ACCESS or mid-RESPOND SHALL drop mem_en and rsp_valid immediately (asynchronously), and the interrupted access SHALL produce no response.
REQ-039 After rst deasserts, the first rising edge with req_valid=1 SHALL be accepted.

Verification
REQ-040 Read with latency=0, addr=0x100, mem_rdata=0xDEADBEEF -> mem_en high for 1 cycle, rsp_valid on the next cycle, rsp_rdata=0xDEADBEEF.
REQ-041 Write with latency=3, addr=0x20, wdata=0x12345678 -> mem_en=mem_we=1 for exactly 4 cycles with addr/wdata stable, then one rsp_valid pulse, rsp_rdata unchanged.
REQ-042 latency=15 read -> mem_en high for 16 cycles; latency input toggled mid-access has no effect on that duration.
REQ-043 req_valid held high continuously with latency=2 -> accepts spaced 5 cycles apart; no request is accepted while busy=1.
REQ-044 rst asserted on the 2nd ACCESS cycle of a latency=5 read -> mem_en=0 immediately, no rsp_valid, block back in IDLE with req_ready=1.

Source files
------------

// File: rtl/mem_request_issuer.sv
// Single-outstanding memory request issuer: capture on accept, hold access for latency+1 cycles, pulse rsp_valid once.
// Accept-to-accept spacing >= latency+3 cycles; req_ready is low while busy and requests are dropped, not queued.
module mem_request_issuer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  latency,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  wait_cnt;
    logic        accept;
    logic        final_cyc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are decoded from state so an async reset drops them immediately.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        final_cyc = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = cap_we;
                if (wait_cnt == 4'd0) begin
                    final_cyc = 1'b1;
                    state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign mem_addr  = cap_addr;
    assign mem_wdata = cap_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            wait_cnt  <= 4'd0;
            rsp_rdata <= 32'd0;
        end else begin
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                wait_cnt  <= latency;
            end else if ((state == ACCESS) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            // Writes leave the last read data visible.
            if (final_cyc && !cap_we) begin
                rsp_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_request_issuer.sv
// Directed bench for mem_request_issuer: inputs driven and outputs sampled on the falling edge.
module tb_mem_request_issuer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  latency;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;

    int checks;
    int failures;

    mem_request_issuer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .latency   (latency),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request, measures the mem_en window, then checks the response cycle.
    task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] lat,
                             input logic [31:0] rdata, input bit toggle_lat,
                             input int exp_len, input logic [31:0] exp_rsp);
        int n;
        bit stable;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        latency   = lat;
        mem_rdata = rdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        n = 0;
        stable = 1'b1;
        while (mem_en && n < 40) begin
            if (mem_addr !== addr || mem_wdata !== wdata || mem_we !== we || busy !== 1'b1
                || req_ready !== 1'b0 || rsp_valid !== 1'b0)
                stable = 1'b0;
            if (toggle_lat) latency = ~latency;
            n++;
            @(negedge clk);
        end
        chk({tag, "_access_len"}, n, exp_len);
        chk({tag, "_access_stable"}, {31'd0, stable}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rsp);
        chk({tag, "_rsp_mem_en"}, {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        chk({tag, "_rsp_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_idle_ready"}, {30'd0, busy, req_ready}, 32'd1);
        chk({tag, "_addr_held"}, mem_addr, addr);
        chk({tag, "_wdata_held"}, mem_wdata, wdata);
        chk({tag, "_rdata_stable"}, rsp_rdata, exp_rsp);
    endtask

    initial begin
        int acc_idx[$];
        int bad;
        int n;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'hFFFF_0000;
        req_wdata = 32'h5555_AAAA;
        latency   = 4'd7;
        mem_rdata = 32'h1111_1111;

        // Reset state, with a request presented that must not be captured.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        req_valid = 1'b0;
        rst = 1'b0;

        do_access("rd_lat0", 1'b0, 32'h0000_0100, 32'h0, 4'd0, 32'hDEAD_BEEF, 1'b0, 1, 32'hDEAD_BEEF);
        do_access("wr_lat3", 1'b1, 32'h0000_0020, 32'h1234_5678, 4'd3, 32'hCAFE_F00D, 1'b0, 4, 32'hDEAD_BEEF);
        do_access("rd_lat15", 1'b0, 32'h0000_03FC, 32'h0BAD_0BAD, 4'd15, 32'hA5A5_5A5A, 1'b1, 16, 32'hA5A5_5A5A);

        // req_valid held high with latency=2: accepts every 5 cycles.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0040;
        latency   = 4'd2;
        mem_rdata = 32'h7777_0001;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (req_ready && req_valid) acc_idx.push_back(i);
            if (busy === req_ready) bad++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_accept_count", acc_idx.size(), 4);
        if (acc_idx.size() >= 3) begin
            chk("b2b_spacing_1", acc_idx[1] - acc_idx[0], 5);
            chk("b2b_spacing_2", acc_idx[2] - acc_idx[1], 5);
        end
        chk("b2b_ready_vs_busy", bad, 0);
        n = 0;
        while (busy && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_drain", {31'd0, busy}, 32'd0);
        chk("b2b_rdata", rsp_rdata, 32'h7777_0001);

        // Reset on the 2nd ACCESS cycle of a latency=5 read.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0500;
        latency   = 4'd5;
        mem_rdata = 32'h9999_9999;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmid_first_access", {31'd0, mem_en}, 32'd1);
        @(negedge clk);
        chk("rmid_second_access", {31'd0, mem_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rmid_mem_en_drop", {31'd0, mem_en}, 32'd0);
        chk("rmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rmid_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rmid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid || busy || mem_en) bad++;
        end
        chk("rmid_no_response", bad, 0);
        chk("rmid_rdata_cleared", rsp_rdata, 32'd0);

        do_access("post_rst", 1'b0, 32'h0000_0600, 32'h0, 4'd1, 32'h0BAD_F00D, 1'b0, 2, 32'h0BAD_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
